mac_sequencer: RTL and testbench

//  Sequences one 4x4-bit MAC unit through an N x N matrix product C = A*B.

---
 rtl/mac_sequencer_if.sv | 28 ++
 rtl/mac_sequencer.sv | 137 +++++++++++++
 tb/tb_mac_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Handshake and data bundle between the MAC sequencer, the operand files, the MAC and the result store.
// master = sequencer side, slave = environment side.
interface mac_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              mac_clear;
  logic              mac_load;
  logic [7:0]        mac_o;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_wdata;
  logic              c_we;
  logic              c_ready;

  modport master (
    input  start, mac_o, c_ready,
    output busy, done, a_addr, b_addr, mac_clear, mac_load, c_addr, c_wdata, c_we
  );

  modport slave (
    output start, mac_o, c_ready,
    input  busy, done, a_addr, b_addr, mac_clear, mac_load, c_addr, c_wdata, c_we
  );
endinterface

// File: rtl/mac_sequencer.sv
// Steps a single 4x4-bit MAC through an N x N matrix product C = A*B, one C element per N+2 cycles.
// Optional PERF_CNT_EN adds a saturating busy-cycle counter on cycle_cnt.
module mac_sequencer #(
  parameter int N      = 4,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mac_sequencer_if.master    bus
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]        cycle_cnt
`endif
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic             busy_w, done_w, clear_w, load_w, we_w;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_CLEAR: begin
        if (N > 1) begin
          state_d = S_FEED;
          k_d     = IDX_W'(1);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FEED: begin
        // k stays at N-1 through DRAIN so the addresses hold.
        if (k_q == LAST) state_d = S_DRAIN;
        else             k_d     = k_q + IDX_W'(1);
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (bus.c_ready) begin
          k_d = '0;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = S_DONE;
            end else begin
              i_d     = i_q + IDX_W'(1);
              state_d = S_CLEAR;
            end
          end else begin
            j_d     = j_q + IDX_W'(1);
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_w  = 1'b0;
    done_w  = 1'b0;
    clear_w = 1'b0;
    load_w  = 1'b0;
    we_w    = 1'b0;
    unique case (state_q)
      S_CLEAR: begin busy_w = 1'b1; clear_w = 1'b1; end
      S_FEED:  begin busy_w = 1'b1; load_w  = 1'b1; end
      S_DRAIN: begin busy_w = 1'b1; load_w  = 1'b1; end
      S_WRITE: begin busy_w = 1'b1; we_w    = 1'b1; end
      S_DONE:  done_w = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = busy_w;
  assign bus.done      = done_w;
  assign bus.mac_clear = clear_w;
  assign bus.mac_load  = load_w;
  assign bus.c_we      = we_w;
  assign bus.c_wdata   = we_w ? bus.mac_o : 8'd0;
  assign bus.a_addr    = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q);
  assign bus.b_addr    = ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);
  assign bus.c_addr    = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);

`ifdef PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && bus.start)   cnt_d = '0;
    else if (busy_w && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer (N=4): behavioural MAC + operand files, timing/value model of the product
// sequence, randomized matrices, c_ready stalls, start noise and a mid-product reset.
module tb_mac_sequencer;
  localparam int N  = 4;
  localparam int NN = N * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_sequencer_if #(.ADDR_W(4)) bus ();
`ifdef PERF_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  mac_sequencer #(.N(N), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  // Operand files and the MAC itself: product on posedge, accumulate on negedge, clear wins.
  logic [3:0] a_mem [NN];
  logic [3:0] b_mem [NN];
  logic [7:0] prod_q = 8'd0;
  logic [7:0] acc_q  = 8'd0;
  always @(posedge clk) prod_q <= a_mem[bus.a_addr] * b_mem[bus.b_addr];
  always @(negedge clk) begin
    if (bus.mac_clear)     acc_q <= 8'd0;
    else if (bus.mac_load) acc_q <= acc_q + prod_q;
  end
  assign bus.mac_o = acc_q;

  logic [7:0] exp_c [NN];
  logic [7:0] c_mem [NN];
  int wr_cyc [NN];
  int tests = 0, fails = 0;
  int ecnt = 0, e0 = 0;
  bit active = 0, arm = 0, kick = 0, noise = 0;
  int stall_mode = 0;
  int wr_idx = 0, last_cmp = 0, done_seen = 0, done_cyc = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += a_mem[i*N+k] * b_mem[k*N+j];
        exp_c[i*N+j] = 8'(s);
      end
  endtask

  // 0: A=identity, B=index; 1: all 15; 2: random
  task automatic fill(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (mode)
          0: begin a_mem[r*N+c] = (r == c) ? 4'd1 : 4'd0; b_mem[r*N+c] = 4'(r*N+c); end
          1: begin a_mem[r*N+c] = 4'd15; b_mem[r*N+c] = 4'd15; end
          default: begin a_mem[r*N+c] = 4'($urandom_range(0, 15)); b_mem[r*N+c] = 4'($urandom_range(0, 15)); end
        endcase
      end
  endtask

  // Stimulus driver: start, c_ready, and cycle-0 bookkeeping, all just after posedge.
  initial begin
    bus.start   = 1'b0;
    bus.c_ready = 1'b1;
    forever begin
      int cyc;
      @(posedge clk);
      #1;
      if (arm) begin e0 = ecnt; active = 1; arm = 0; end
      cyc = ecnt - e0 + 1;
      if (kick) begin bus.start = 1'b1; kick = 0; arm = 1; end
      else if (active && noise) bus.start = ($urandom_range(0, 3) == 0);
      else bus.start = 1'b0;
      case (stall_mode)
        1:       bus.c_ready = !(active && cyc >= 6 && cyc <= 8);
        2:       bus.c_ready = active ? ($urandom_range(0, 2) != 0) : 1'b1;
        default: bus.c_ready = 1'b1;
      endcase
    end
  end

  // Compare process: element m starts the cycle after write m-1 completes (cycle 0 = accept edge):
  // clear at +1, loads at +2..+N+1, write strobe from +N+2 until c_ready; done the cycle after the last write.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("clear_load_excl", 32'(bus.mac_clear & bus.mac_load), 0);
        if (active) begin
          int cyc, ii, jj, kk;
          bit fin;
          cyc = ecnt - e0 + 1;
          fin = (wr_idx == NN);
          ii  = wr_idx / N;
          jj  = wr_idx % N;
          check("busy",      32'(bus.busy),      32'(!fin));
          check("done",      32'(bus.done),      32'(fin && cyc == last_cmp + 1));
          check("mac_clear", 32'(bus.mac_clear), 32'(!fin && cyc == last_cmp + 1));
          check("mac_load",  32'(bus.mac_load),  32'(!fin && cyc >= last_cmp + 2 && cyc <= last_cmp + N + 1));
          check("c_we",      32'(bus.c_we),      32'(!fin && cyc >= last_cmp + N + 2));
          if (!fin && cyc <= last_cmp + N) begin
            kk = cyc - last_cmp - 1;
            check("a_addr", 32'(bus.a_addr), 32'(ii*N + kk));
            check("b_addr", 32'(bus.b_addr), 32'(kk*N + jj));
          end
          if (!fin && bus.c_we) begin
            check("c_addr",  32'(bus.c_addr),  32'(wr_idx));
            check("c_wdata", 32'(bus.c_wdata), 32'(exp_c[wr_idx]));
            if (bus.c_ready) begin
              c_mem[bus.c_addr] = bus.c_wdata;
              wr_cyc[wr_idx]    = cyc;
              wr_idx++;
              last_cmp = cyc;
            end
          end
          if (fin && cyc >= last_cmp + 1) begin
            if (bus.done) begin done_seen++; done_cyc = cyc; end
            active = 0;
          end
        end else begin
          check("idle_we",   32'(bus.c_we), 0);
          check("idle_done", 32'(bus.done), 0);
        end
      end
    end
  end

  task automatic start_product(input int smode, input bit nz);
    build_model();
    for (int m = 0; m < NN; m++) begin c_mem[m] = 8'd0; wr_cyc[m] = 0; end
    wr_idx = 0; last_cmp = 0; done_seen = 0; done_cyc = 0;
    stall_mode = smode;
    noise = nz;
    @(negedge clk);
    kick = 1;
  endtask

  task automatic run_product(input int smode, input bit nz);
    start_product(smode, nz);
    for (int t = 0; t < 600 && done_seen == 0; t++) @(posedge clk);
    if (done_seen == 0) active = 0;
    check("done_seen", 32'(done_seen), 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("done_count",  32'(done_seen), 1);
    check("write_count", 32'(wr_idx), NN);
    check("busy_after",  32'(bus.busy), 0);
    for (int m = 0; m < NN; m++) check("c_mem", 32'(c_mem[m]), 32'(exp_c[m]));
    noise = 0;
    stall_mode = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(bus.busy), 0);
    check({tag, "_done"},   32'(bus.done), 0);
    check({tag, "_we"},     32'(bus.c_we), 0);
    check({tag, "_clear"},  32'(bus.mac_clear), 0);
    check({tag, "_load"},   32'(bus.mac_load), 0);
    check({tag, "_a_addr"}, 32'(bus.a_addr), 0);
    check({tag, "_b_addr"}, 32'(bus.b_addr), 0);
    check({tag, "_c_addr"}, 32'(bus.c_addr), 0);
    check({tag, "_wdata"},  32'(bus.c_wdata), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // identity * index matrix reproduces B; literal timing pins
    fill(0);
    run_product(0, 0);
    check("id_c5",      32'(c_mem[5]), 5);
    check("id_c14",     32'(c_mem[14]), 14);
    check("id_wr0_cyc", 32'(wr_cyc[0]), 6);
    check("id_wr15_cyc",32'(wr_cyc[15]), 96);
    check("id_done_cyc",32'(done_cyc), 97);
`ifdef PERF_CNT_EN
    check("cycle_cnt", 32'(cycle_cnt), 96);
    repeat (5) @(negedge clk);
    check("cycle_cnt_hold", 32'(cycle_cnt), 96);
`endif

    // all 15s: 4*225 = 900 wraps to 132
    fill(1);
    run_product(0, 0);
    check("max_c0",  32'(c_mem[0]), 132);
    check("max_c15", 32'(c_mem[15]), 132);

    // three-cycle stall on the first write
    fill(2);
    run_product(1, 0);
    check("stall_wr0_cyc", 32'(wr_cyc[0]), 9);
    check("stall_wr1_cyc", 32'(wr_cyc[1]), 15);
    check("stall_done_cyc",32'(done_cyc), 100);

    // start noise while busy
    fill(2);
    run_product(0, 1);

    // reset during FEED of element 5, then a clean product
    fill(2);
    start_product(0, 0);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #2;
      if (active && (ecnt - e0 + 1) == 33) break;
    end
    check("abort_reached", 32'(active && (ecnt - e0 + 1) == 33), 1);
    active = 0;
    rst_n  = 1'b0;
    #1;
    check_all_zero("abort");
    check("abort_writes", 32'(wr_idx), 5);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill(2);
    run_product(0, 0);

    // random matrices with random back-pressure
    for (int r = 0; r < 3; r++) begin
      fill(2);
      run_product(2, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

endmodule
